// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller sitting behind the hazard detector.
// Decodes the per-cycle hazard code into stage enables, IF/ID flush and
// ID/EX bubble select, sequences cache-miss waits and multi-cycle branch
// flushes, and keeps saturating performance counters.
module pipe_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MISS_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       hazType,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             miss_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_MISS  = 2'd2;

  localparam logic [1:0] HZ_DATA = 2'd1;
  localparam logic [1:0] HZ_CTRL = 2'd2;
  localparam logic [1:0] HZ_MISS = 2'd3;

  localparam logic [3:0]       FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0]      TIMEOUT_LIM  = 16'(MISS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [15:0]      WAIT_MAX     = '1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       flush_rem_q, flush_rem_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Same-cycle stage control decode, in priority order:
  // miss wait > new miss > flush state > control > data > none.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (state_q == S_MISS) begin
      // mem_ready releases every stage in the same cycle; hazType ignored
      if (!mem_ready) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
    end else if (hazType == HZ_MISS) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (state_q == S_FLUSH || hazType == HZ_CTRL) begin
      ifid_flush = 1'b1;
    end else if (hazType == HZ_DATA) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Event sequencing: next state, flush/wait counters, timeout and perf counters
  always_comb begin
    state_d     = state_q;
    flush_rem_d = flush_rem_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    flush_cnt_d = flush_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (!pc_en && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    if (state_q == S_MISS) begin
      if (mem_ready) begin
        // flush_rem survived the miss, so an interrupted flush resumes here
        state_d = (flush_rem_q != 4'd0) ? S_FLUSH : S_RUN;
      end else begin
        if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (wait_cnt_d >= TIMEOUT_LIM) begin
          timeout_d = 1'b1;
        end
      end
    end else if (hazType == HZ_MISS) begin
      state_d    = S_MISS;
      wait_cnt_d = '0;
      if (miss_cnt_q != CNT_MAX) begin
        miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end else if (hazType == HZ_CTRL) begin
      // a new control hazard (re)starts the flush window from RUN or FLUSH
      if (flush_cnt_q != CNT_MAX) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
      if (FLUSH_CYCLES > 1) begin
        flush_rem_d = FLUSH_RELOAD;
        state_d     = S_FLUSH;
      end else begin
        flush_rem_d = '0;
        state_d     = S_RUN;
      end
    end else if (state_q == S_FLUSH) begin
      if (flush_rem_q <= 4'd1) begin
        flush_rem_d = '0;
        state_d     = S_RUN;
      end else begin
        flush_rem_d = flush_rem_q - 1'b1;
      end
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      flush_rem_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign miss_timeout = timeout_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl (FLUSH_CYCLES=3, MISS_TIMEOUT=4).
// The driver applies one vector per cycle and queues its expected response;
// the monitor pops and compares on the following falling edge.
module tb_pipe_stall_ctrl;

  localparam int unsigned CW = 16;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_en, memwb_en}
  localparam logic [6:0] C_NORM  = 7'b1100111;
  localparam logic [6:0] C_STALL = 7'b0001111;
  localparam logic [6:0] C_FLSH  = 7'b1110111;
  localparam logic [6:0] C_MISS  = 7'b0000000;

  typedef struct {
    int          id;
    logic        chk;
    logic [6:0]  ctl;
    logic [CW-1:0] s, f, m;
    logic        t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    hazType = 2'd0;
  logic          mem_ready = 1'b0;
  logic          pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_en, memwb_en;
  logic          miss_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, miss_cnt;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vid    = 0;

  pipe_stall_ctrl #(
    .FLUSH_CYCLES(3),
    .MISS_TIMEOUT(4),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hazType(hazType),
    .mem_ready(mem_ready),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .idex_en(idex_en),
    .exmem_en(exmem_en),
    .memwb_en(memwb_en),
    .miss_timeout(miss_timeout),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic vec(input logic r, input logic [1:0] h, input logic mr, input logic chk,
                     input logic [6:0] c, input int s, input int f, input int m, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = r;
    hazType   = h;
    mem_ready = mr;
    vid++;
    e.id  = vid;
    e.chk = chk;
    e.ctl = c;
    e.s   = CW'(s);
    e.f   = CW'(f);
    e.m   = CW'(m);
    e.t   = t;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle presents a response; compare it against the queue head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = exp_q.pop_front();
      if (e.chk) begin
        act = {pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_en, memwb_en};
        n_vec++;
        if (act !== e.ctl || stall_cnt !== e.s || flush_cnt !== e.f ||
            miss_cnt !== e.m || miss_timeout !== e.t) begin
          n_miss++;
          $display("FAIL vec%0d: got ctl=%b s=%0d f=%0d m=%0d to=%b, need ctl=%b s=%0d f=%0d m=%0d to=%b",
                   e.id, act, stall_cnt, flush_cnt, miss_cnt, miss_timeout,
                   e.ctl, e.s, e.f, e.m, e.t);
        end
      end
    end
  end

  initial begin
    // power-up reset, unchecked while state is undefined
    vec(0, 0, 0, 0, C_NORM, 0, 0, 0, 0);
    vec(0, 0, 0, 0, C_NORM, 0, 0, 0, 0);
    // reset state
    vec(1, 0, 0, 1, C_NORM, 0, 0, 0, 0);
    // data stall x3
    vec(1, 1, 0, 1, C_STALL, 0, 0, 0, 0);
    vec(1, 1, 0, 1, C_STALL, 1, 0, 0, 0);
    vec(1, 1, 0, 1, C_STALL, 2, 0, 0, 0);
    vec(1, 0, 0, 1, C_NORM,  3, 0, 0, 0);
    // branch flush, 3 cycles from one hazType=2
    vec(1, 2, 0, 1, C_FLSH, 3, 0, 0, 0);
    vec(1, 0, 0, 1, C_FLSH, 3, 1, 0, 0);
    vec(1, 0, 0, 1, C_FLSH, 3, 1, 0, 0);
    vec(1, 0, 0, 1, C_NORM, 3, 1, 0, 0);
    // cache miss, mem_ready after 5 wait cycles (timeout 4 trips)
    vec(1, 3, 0, 1, C_MISS, 3, 1, 0, 0);
    vec(1, 0, 0, 1, C_MISS, 4, 1, 1, 0);
    vec(1, 0, 0, 1, C_MISS, 5, 1, 1, 0);
    vec(1, 0, 0, 1, C_MISS, 6, 1, 1, 0);
    vec(1, 0, 0, 1, C_MISS, 7, 1, 1, 0);
    vec(1, 0, 0, 1, C_MISS, 8, 1, 1, 1);
    vec(1, 1, 1, 1, C_NORM, 9, 1, 1, 1);  // release: hazType ignored
    vec(1, 0, 0, 1, C_NORM, 9, 1, 1, 1);  // timeout sticky
    // reset in the middle of a miss wait
    vec(1, 3, 0, 1, C_MISS, 9,  1, 1, 1);
    vec(1, 0, 0, 1, C_MISS, 10, 1, 2, 1);
    vec(0, 0, 0, 1, C_MISS, 11, 1, 2, 1);
    vec(0, 0, 0, 1, C_NORM, 0, 0, 0, 0);
    vec(1, 0, 1, 1, C_NORM, 0, 0, 0, 0);  // stale mem_ready in RUN does nothing
    // miss during flush: one flush cycle remains after release
    vec(1, 2, 0, 1, C_FLSH, 0, 0, 0, 0);
    vec(1, 0, 0, 1, C_FLSH, 0, 1, 0, 0);
    vec(1, 3, 0, 1, C_MISS, 0, 1, 0, 0);
    vec(1, 0, 0, 1, C_MISS, 1, 1, 1, 0);
    vec(1, 2, 1, 1, C_NORM, 2, 1, 1, 0);
    vec(1, 0, 0, 1, C_FLSH, 2, 1, 1, 0);
    vec(1, 0, 0, 1, C_NORM, 2, 1, 1, 0);
    // timeout: mem_ready low for 10 wait cycles
    vec(1, 3, 0, 1, C_MISS, 2, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      vec(1, 0, 0, 1, C_MISS, 3 + i, 1, 2, (i >= 4) ? 1'b1 : 1'b0);
    end
    vec(1, 0, 1, 1, C_NORM,  13, 1, 2, 1);
    vec(1, 0, 0, 1, C_NORM,  13, 1, 2, 1);
    vec(1, 1, 0, 1, C_STALL, 13, 1, 2, 1);
    vec(1, 0, 0, 1, C_NORM,  14, 1, 2, 1);
    // flush reload and data hazard overridden by flush
    vec(1, 2, 0, 1, C_FLSH, 14, 1, 2, 1);
    vec(1, 2, 0, 1, C_FLSH, 14, 2, 2, 1);
    vec(1, 1, 0, 1, C_FLSH, 14, 3, 2, 1);
    vec(1, 0, 0, 1, C_FLSH, 14, 3, 2, 1);
    vec(1, 0, 0, 1, C_NORM, 14, 3, 2, 1);

    // let the monitor drain, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
